flit_source: RTL and testbench
==============================

// Module: flit_source
// PURPOSE
//  Credit-based packet injector; the transmit end of the router channel that flit_sink terminates.
//  Accepts packet requests, then serializes each packet onto the router input channel:
//  one head flit followed by N payload flits.
//  Tracks per-VC downstream buffer credits and consumes the credit returns on flow_ctrl.
//  Used in network testbenches as the terminal-side traffic source feeding a router injection port.
// PARAMETERS
//  num_vcs              8   number of VCs; vc_idx_width = clogb(num_vcs)
//  buffer_size          64  downstream flits per port; credits per VC = buffer_size/num_vcs
//  flit_data_width      64  flit payload width
//  max_payload_length   4   max payload flits per packet
//  min_payload_length   1   min payload flits per packet; plw = clogb(max-min+1)
//  route_info_width     14  destination/route field width in the head flit
//  router_addr_width    4   width of the local router address
//  pkt_cnt_width        32  packet sequence counter width
// PORTS
//  clk            in   1   clock
//  reset          in   1   asynchronous active-high reset
//  router_address in   router_addr_width   local (source) router address
//  req_valid      in   1   packet request present
//  req_ready      out  1   request accepted when req_valid & req_ready
//  req_vc         in   vc_idx_width        VC to inject on
//  req_route      in   route_info_width    route info copied into the head flit
//  req_length     in   plw                 payload length code (flits = code + min_payload_length)
//  channel        out  1+1+vc_idx_width+1+flit_data_width
//                      {link_active, flit_valid, vc, head, data}, MSB-first ([0:W-1])
//  flow_ctrl      in   1+vc_idx_width      {credit_valid, credit_vc} from the downstream sink
//  pkt_cnt        out  pkt_cnt_width       packets fully sent since reset
//  error          out  1   sticky; credit overflow or illegal request
// BEHAVIOUR
//  Reset (async): channel=0, req_ready=1, pkt_cnt=0, error=0, state=IDLE.
//   Every credit counter = buffer_size/num_vcs.
//  FSM states:
//   IDLE: req_ready=1. On req_valid, latch vc/route/length and go to HEAD.
//   HEAD: req_ready=0. Issue the head flit when credit[vc]!=0, then go to BODY; otherwise stall in HEAD.
//   BODY: req_ready=0. Issue one payload flit per cycle while credit[vc]!=0.
//    After the last payload flit: go to IDLE and increment pkt_cnt (wraps at 2^pkt_cnt_width).
//  Issue semantics:
//   Registered: the flit decided at edge N is visible on channel during cycle N+1.
//   The credit decrement happens at edge N. Latency from request acceptance to head flit = 2 cycles min.
//  Channel fields:
//   flit_valid=1 only in a cycle where a flit was issued; otherwise valid=0 and vc/head/data=0.
//   link_active=1 whenever state!=IDLE or flit_valid=1.
//  Head data: [0:route_info_width-1]=route; next plw bits=length code; rest 0.
//  Payload data:
//   Low router_addr_width bits = router_address.
//   The pkt_cnt_width bits above those = current pkt_cnt (value before increment).
//   All remaining bits = 0.
//  Credits:
//   flow_ctrl credit_valid increments credit[credit_vc] at the same edge.
//   Simultaneous issue and return on the same VC leaves the count unchanged.
//   A return with the count already at max sets error and saturates the count.
//  A req_length code > max-min sets error; the packet is still sent with a truncated length.
//  Only one packet is in flight per source; VCs are not interleaved.
//  Reset mid-packet: aborts immediately; no tail is owed because the sink resets with the source.
// TESTING
//  T1 reset: drive reset for 2 cycles.
//   -> channel=0, req_ready=1, pkt_cnt=0, error=0, all 8 credits=8.
//  T2 single packet: vc=2, route=0x5, code=2 (3 payload flits), router_address=0x9.
//   -> head data[0:13]=0x5, then 3 flits with low 4 bits=0x9 and pkt_cnt field=0; pkt_cnt=1; credit[2]=4.
//  T3 exhaustion: no returns; two code=3 packets on VC0.
//   -> 8 flits sent, valid=0 stall with credit[0]=0.
//   -> A credit return on VC0 resumes the flit in the next cycle.
//  T4 collision: a credit return on VC1 in the same cycle as a VC1 issue.
//   -> credit[1] unchanged, no error.
//  T5 overflow: credit return on VC3 while credit[3]=8 -> error=1 (sticky), credit[3]=8.
//  T6 abort: assert reset during the 2nd payload flit.
//   -> channel=0 in the same cycle, FSM=IDLE, credits restored to 8.

Source files
------------

// File: rtl/flit_source_if.sv
// Packet request channel into flit_source.
// Handshake: the requester holds req_valid and the req_* fields steady until the
// cycle in which req_valid & req_ready are both high; the request is taken on that
// rising clock edge. req_ready never depends combinationally on req_valid.
interface flit_source_if #(
  parameter int vc_idx_width     = 3,
  parameter int route_info_width = 14,
  parameter int plw              = 2
);
  logic                        req_valid;
  logic                        req_ready;
  logic [vc_idx_width-1:0]     req_vc;
  logic [route_info_width-1:0] req_route;
  logic [plw-1:0]              req_length;

  modport master (
    output req_valid,
    output req_vc,
    output req_route,
    output req_length,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_vc,
    input  req_route,
    input  req_length,
    output req_ready
  );
endinterface

// File: rtl/flit_source.sv
// Credit-based packet injector: takes one packet request at a time and serializes
// it as a head flit plus N payload flits onto the router input channel, spending
// one downstream credit per flit and collecting credit returns from flow_ctrl.
module flit_source #(
  parameter int num_vcs            = 8,
  parameter int buffer_size        = 64,
  parameter int flit_data_width    = 64,
  parameter int max_payload_length = 4,
  parameter int min_payload_length = 1,
  parameter int route_info_width   = 14,
  parameter int router_addr_width  = 4,
  parameter int pkt_cnt_width      = 32,
  localparam int vc_idx_width   = (num_vcs > 1) ? $clog2(num_vcs) : 1,
  localparam int plw            = (max_payload_length - min_payload_length + 1 > 1) ?
                                  $clog2(max_payload_length - min_payload_length + 1) : 1,
  localparam int chan_w         = 3 + vc_idx_width + flit_data_width,
  localparam int credits_per_vc = buffer_size / num_vcs,
  localparam int crw            = $clog2(credits_per_vc + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [router_addr_width-1:0]   router_address,
  flit_source_if.slave                   req,
  output logic [0:chan_w-1]              channel,
  input  logic [vc_idx_width:0]          flow_ctrl,
  output logic [pkt_cnt_width-1:0]       pkt_cnt,
  output logic                           error,
  output logic [1:0]                     state_dbg,
  output logic [num_vcs*crw-1:0]         credit_dbg
);

  localparam int len_w = $clog2(max_payload_length + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2
  } state_t;

  state_t                      state_q, state_n;
  logic [vc_idx_width-1:0]     vc_q, vc_n;
  logic [route_info_width-1:0] route_q, route_n;
  logic [plw-1:0]              code_q, code_n;
  logic [len_w-1:0]            left_q, left_n;
  logic [crw-1:0]              credit_q [num_vcs];
  logic [crw-1:0]              credit_n [num_vcs];
  logic                        flit_valid_q, flit_valid_n;
  logic                        flit_head_q, flit_head_n;
  logic [vc_idx_width-1:0]     flit_vc_q, flit_vc_n;
  logic [flit_data_width-1:0]  flit_data_q, flit_data_n;
  logic [pkt_cnt_width-1:0]    pkt_cnt_q, pkt_cnt_n;
  logic                        error_q, error_n;

  logic                        accept;
  logic                        issue;
  logic                        last;
  logic                        len_illegal;
  logic [plw-1:0]              code_legal;
  logic [len_w-1:0]            req_flits;
  logic [flit_data_width-1:0]  head_data;
  logic [flit_data_width-1:0]  payload_data;
  logic                        credit_valid;
  logic [vc_idx_width-1:0]     credit_vc;
  logic [num_vcs-1:0]          ovf_hit;
  logic                        link_active;

  assign credit_valid = flow_ctrl[vc_idx_width];
  assign credit_vc    = flow_ctrl[vc_idx_width-1:0];

  // Oversized length codes are flagged and clamped to the longest legal packet.
  assign len_illegal = (32'(req.req_length) > 32'(max_payload_length - min_payload_length));
  assign code_legal  = len_illegal ? plw'(max_payload_length - min_payload_length) : req.req_length;
  assign req_flits   = len_w'(code_legal) + len_w'(min_payload_length);

  // Head carries route in the top bits then the length code; payload carries
  // the source address in the low bits with the packet number above it.
  assign head_data    = flit_data_width'({route_q, code_q}) << (flit_data_width - route_info_width - plw);
  assign payload_data = flit_data_width'({pkt_cnt_q, router_address});

  assign req.req_ready = (state_q == S_IDLE);

  // Packet sequencing: accept a request, then one flit per cycle whenever the VC has credit.
  always_comb begin
    state_n     = state_q;
    vc_n        = vc_q;
    route_n     = route_q;
    code_n      = code_q;
    left_n      = left_q;
    accept      = 1'b0;
    issue       = 1'b0;
    last        = 1'b0;
    flit_head_n = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req.req_valid) begin
          accept  = 1'b1;
          vc_n    = req.req_vc;
          route_n = req.req_route;
          code_n  = code_legal;
          left_n  = req_flits;
          state_n = S_HEAD;
        end
      end
      S_HEAD: begin
        if (credit_q[vc_q] != '0) begin
          issue       = 1'b1;
          flit_head_n = 1'b1;
          state_n     = S_BODY;
        end
      end
      S_BODY: begin
        if (credit_q[vc_q] != '0) begin
          issue  = 1'b1;
          left_n = left_q - len_w'(1);
          if (left_q == len_w'(1)) begin
            last    = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    flit_valid_n = issue;
    flit_vc_n    = issue ? vc_q : '0;
    if (!issue)
      flit_data_n = '0;
    else if (flit_head_n)
      flit_data_n = head_data;
    else
      flit_data_n = payload_data;
    pkt_cnt_n = last ? pkt_cnt_q + pkt_cnt_width'(1) : pkt_cnt_q;
  end

  // Per-VC credit arithmetic: issue spends, return refunds, both on one VC cancel out.
  always_comb begin
    ovf_hit = '0;
    for (int v = 0; v < num_vcs; v++) begin
      credit_n[v] = credit_q[v];
      if (credit_valid && credit_vc == vc_idx_width'(v)) begin
        if (issue && vc_q == vc_idx_width'(v))
          credit_n[v] = credit_q[v];
        else if (credit_q[v] == crw'(credits_per_vc))
          ovf_hit[v] = 1'b1;
        else
          credit_n[v] = credit_q[v] + crw'(1);
      end else if (issue && vc_q == vc_idx_width'(v)) begin
        credit_n[v] = credit_q[v] - crw'(1);
      end
    end
  end

  assign error_n = error_q | (|ovf_hit) | (accept & len_illegal);

  // State, packet context, credits and the registered channel flit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      vc_q         <= '0;
      route_q      <= '0;
      code_q       <= '0;
      left_q       <= '0;
      flit_valid_q <= 1'b0;
      flit_head_q  <= 1'b0;
      flit_vc_q    <= '0;
      flit_data_q  <= '0;
      pkt_cnt_q    <= '0;
      error_q      <= 1'b0;
      for (int v = 0; v < num_vcs; v++) credit_q[v] <= crw'(credits_per_vc);
    end else begin
      state_q      <= state_n;
      vc_q         <= vc_n;
      route_q      <= route_n;
      code_q       <= code_n;
      left_q       <= left_n;
      flit_valid_q <= flit_valid_n;
      flit_head_q  <= flit_head_n;
      flit_vc_q    <= flit_vc_n;
      flit_data_q  <= flit_data_n;
      pkt_cnt_q    <= pkt_cnt_n;
      error_q      <= error_n;
      for (int v = 0; v < num_vcs; v++) credit_q[v] <= credit_n[v];
    end
  end

  // The link stays active while a packet is owed and through its final flit.
  assign link_active = (state_q != S_IDLE) | flit_valid_q;
  assign channel     = {link_active, flit_valid_q, flit_vc_q, flit_head_q, flit_data_q};
  assign pkt_cnt     = pkt_cnt_q;
  assign error       = error_q;
  assign state_dbg   = state_q;

  // Flatten the credit counters for observation.
  always_comb begin
    credit_dbg = '0;
    for (int v = 0; v < num_vcs; v++) credit_dbg[v*crw +: crw] = credit_q[v];
  end

endmodule

// File: tb/tb_flit_source.sv
`timescale 1ns/1ps
module tb_flit_source;
  localparam int NV   = 8;
  localparam int VW   = 3;
  localparam int RW   = 14;
  localparam int PL   = 2;
  localparam int FDW  = 64;
  localparam int AW   = 4;
  localparam int PCW  = 32;
  localparam int CRW  = 4;
  localparam int CW   = 70;
  localparam int CMAX = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0]      router_address;
  logic [0:CW-1]      channel;
  logic [VW:0]        flow_ctrl;
  logic [PCW-1:0]     pkt_cnt;
  logic               error;
  logic [1:0]         state_dbg;
  logic [NV*CRW-1:0]  credit_dbg;

  flit_source_if #(.vc_idx_width(VW), .route_info_width(RW), .plw(PL)) rq();

  flit_source dut (
    .clk(clk),
    .reset(reset),
    .router_address(router_address),
    .req(rq),
    .channel(channel),
    .flow_ctrl(flow_ctrl),
    .pkt_cnt(pkt_cnt),
    .error(error),
    .state_dbg(state_dbg),
    .credit_dbg(credit_dbg)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds the flits still owed: {last, head, vc[2:0], data[63:0]}.
  logic [68:0]    exp_q[$];
  int             m_cred[NV];
  logic           m_valid;
  logic           m_head;
  logic [VW-1:0]  m_vc;
  logic [FDW-1:0] m_data;
  logic [PCW-1:0] m_pkt;
  logic           m_err;
  logic [67:0]    log_q[$];

  task automatic model_step();
    logic [68:0] f;
    bit was_empty, iss;
    int ivc, cv, n;
    if (reset) begin
      exp_q.delete();
      for (int v = 0; v < NV; v++) m_cred[v] = CMAX;
      m_valid = 0; m_head = 0; m_vc = '0; m_data = '0; m_pkt = '0; m_err = 0;
      return;
    end
    was_empty = (exp_q.size() == 0);
    iss = 0; ivc = 0;
    m_valid = 0; m_head = 0; m_vc = '0; m_data = '0;
    if (!was_empty) begin
      f = exp_q[0];
      ivc = int'(f[66:64]);
      if (m_cred[ivc] > 0) begin
        void'(exp_q.pop_front());
        iss = 1;
        m_valid = 1; m_head = f[67]; m_vc = f[66:64]; m_data = f[63:0];
        if (f[68]) m_pkt = m_pkt + 1;
      end
    end
    if (iss) m_cred[ivc] = m_cred[ivc] - 1;
    if (flow_ctrl[VW]) begin
      cv = int'(flow_ctrl[VW-1:0]);
      if (iss && cv == ivc) m_cred[cv] = m_cred[cv] + 1;
      else if (m_cred[cv] == CMAX) m_err = 1;
      else m_cred[cv] = m_cred[cv] + 1;
    end
    if (was_empty && rq.req_valid) begin
      n = int'(rq.req_length) + 1;
      exp_q.push_back({1'b0, 1'b1, rq.req_vc,
                       (64'(rq.req_route) << 50) | (64'(rq.req_length) << 48)});
      for (int i = 0; i < n; i++)
        exp_q.push_back({(i == n - 1), 1'b0, rq.req_vc, (64'(m_pkt) << 4) | 64'(router_address)});
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // ---------------- scoreboard compare, every cycle ----------------
  initial forever begin
    logic [NV*CRW-1:0] ec;
    @(negedge clk);
    ec = '0;
    for (int v = 0; v < NV; v++) ec[v*CRW +: CRW] = CRW'(m_cred[v]);
    check("channel", channel, {((exp_q.size() > 0) || m_valid), m_valid, m_vc, m_head, m_data});
    check("req_ready", rq.req_ready, (exp_q.size() == 0));
    check("pkt_cnt", pkt_cnt, m_pkt);
    check("error", error, m_err);
    check("credits", credit_dbg, ec);
    if (channel[1]) log_q.push_back({channel[5], channel[2:4], channel[6:69]});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input int vc, input int route, input int code);
    bit acc = 0;
    int n = 0;
    rq.req_valid  = 1'b1;
    rq.req_vc     = 3'(vc);
    rq.req_route  = 14'(route);
    rq.req_length = 2'(code);
    while (!acc && n < 200) begin
      acc = rq.req_ready;
      tick();
      n++;
    end
    rq.req_valid = 1'b0;
    check("req_accept", acc, 1'b1);
  endtask

  task automatic credit_ret(input int vc);
    flow_ctrl = {1'b1, 3'(vc)};
    tick();
    flow_ctrl = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(rq.req_ready && !channel[1]) && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle", (n < budget), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n, seen;
    reset = 1'b1;
    flow_ctrl = '0;
    router_address = 4'h9;
    rq.req_valid = 1'b0; rq.req_vc = '0; rq.req_route = '0; rq.req_length = '0;

    // T1 reset
    repeat (2) @(posedge clk);
    #1;
    check("t1_channel", channel, 0);
    check("t1_ready", rq.req_ready, 1);
    check("t1_pkt_cnt", pkt_cnt, 0);
    check("t1_error", error, 0);
    check("t1_credits", credit_dbg, 32'h8888_8888);
    check("t1_state", state_dbg, 0);
    reset = 1'b0;
    tick();

    // T2 single packet on VC2
    log_q.delete();
    send_req(2, 14'h5, 2);
    wait_idle(50);
    check("t2_nflits", log_q.size(), 4);
    if (log_q.size() >= 4) begin
      check("t2_head", log_q[0], {1'b1, 3'd2, 64'h0016_0000_0000_0000});
      for (int i = 1; i < 4; i++) check("t2_payload", log_q[i], {1'b0, 3'd2, 64'h9});
    end
    check("t2_pkt_cnt", pkt_cnt, 1);
    check("t2_credit2", credit_dbg[11:8], 4);

    // T3 credit exhaustion on VC0
    log_q.delete();
    send_req(0, 14'h100, 3);
    send_req(0, 14'h101, 3);
    n = 0;
    while (credit_dbg[3:0] != 4'd0 && n < 50) begin tick(); n++; end
    check("t3_drain", (n < 50), 1'b1);
    tick(); tick();
    check("t3_stall_valid", channel[1], 0);
    check("t3_flits", log_q.size(), 8);
    check("t3_credit0", credit_dbg[3:0], 0);
    credit_ret(0);
    check("t3_still_stalled", channel[1], 0);
    credit_ret(0);
    check("t3_resume", {channel[1], channel[5]}, 2'b10);
    for (int i = 0; i < 8; i++) credit_ret(0);
    wait_idle(50);
    check("t3_total", log_q.size(), 10);
    if (log_q.size() == 10) check("t3_last", log_q[9], {1'b0, 3'd0, 64'h29});
    check("t3_credit0_back", credit_dbg[3:0], 8);
    check("t3_pkt_cnt", pkt_cnt, 3);
    check("t3_error", error, 0);

    // T4 collision on VC1
    send_req(1, 14'h3a, 0);
    credit_ret(1);
    check("t4_credit1", credit_dbg[7:4], 8);
    check("t4_error", error, 0);
    wait_idle(50);
    check("t4_credit1_end", credit_dbg[7:4], 7);

    // T5 overflow on VC3
    credit_ret(3);
    check("t5_error", error, 1);
    check("t5_credit3", credit_dbg[15:12], 8);
    repeat (3) tick();
    check("t5_sticky", error, 1);

    // T6 abort during the second payload flit
    send_req(4, 14'h1234, 3);
    n = 0; seen = 0;
    while (seen < 2 && n < 30) begin
      tick();
      n++;
      if (channel[1] && !channel[5]) seen++;
    end
    check("t6_reach", seen, 2);
    #1 reset = 1'b1;
    #1;
    check("t6_channel", channel, 0);
    check("t6_ready", rq.req_ready, 1);
    check("t6_state", state_dbg, 0);
    check("t6_credits", credit_dbg, 32'h8888_8888);
    check("t6_error", error, 0);
    check("t6_pkt_cnt", pkt_cnt, 0);
    tick();
    reset = 1'b0;
    tick();

    // Recovery packet after abort
    log_q.delete();
    send_req(7, 14'h3fff, 1);
    wait_idle(50);
    check("t6_rec_nflits", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("t6_rec_head", log_q[0], {1'b1, 3'd7, 64'hFFFD_0000_0000_0000});
      check("t6_rec_last", log_q[2], {1'b0, 3'd7, 64'h9});
    end
    check("t6_rec_pkt_cnt", pkt_cnt, 1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
